// File: rtl/id_ex_queue_pkg.sv
// Shared ID->EX pipeline definitions: the decoded packet layout and the
// queue sizing constants used by id_ex_queue.
package id_ex_queue_pkg;

  typedef struct packed {
    logic [3:0]   wb_ctrl;
    logic [3:0]   mem_ctrl;
    logic [7:0]   ex_ctrl;
    logic [175:0] ex_data;
  } type_ID_EX_Pack;

  localparam int ID_EX_PACK_W      = $bits(type_ID_EX_Pack);
  localparam int ID_EX_QUEUE_DEPTH = 4;

endpackage

// File: rtl/id_ex_queue_ctrl.sv
// Pointer/occupancy control for id_ex_queue: push/pop decision, count, status
// flags and sticky overflow. ID_EX_QUEUE_BYPASS_EN enables empty-queue bypass.
module id_ex_queue_ctrl import id_ex_queue_pkg::*; #(
  parameter int DEPTH = ID_EX_QUEUE_DEPTH,
  parameter int AW    = $clog2(DEPTH)
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          wen_i,
  input  logic          flush_i,
  input  logic          rready_i,
  output logic [AW-1:0] wr_ptr_o,
  output logic [AW-1:0] rd_ptr_o,
  output logic [AW:0]   count_o,
  output logic          full_o,
  output logic          almost_full_o,
  output logic          overflow_o,
  output logic          rvalid_o,
  output logic          push_o,
  output logic          bypass_o
);

  localparam logic [AW:0] DEPTH_C = (AW+1)'(DEPTH);

  logic [AW-1:0] wr_ptr_q, wr_ptr_d;
  logic [AW-1:0] rd_ptr_q, rd_ptr_d;
  logic [AW:0]   count_q, count_d;
  logic          overflow_q, overflow_d;

  logic empty_s, full_s, pop_s, push_s, byp_s, byp_take_s, drop_s;

  assign empty_s = (count_q == '0);
  assign full_s  = (count_q == DEPTH_C);

`ifdef ID_EX_QUEUE_BYPASS_EN
  assign byp_s = empty_s & wen_i & ~flush_i;
`else
  assign byp_s = 1'b0;
`endif

  // A bypassed packet taken by EX in the same cycle never touches storage.
  assign byp_take_s = byp_s & rready_i;
  assign pop_s      = ~empty_s & rready_i;
  assign push_s     = wen_i & ~flush_i & (~full_s | pop_s) & ~byp_take_s;
  assign drop_s     = wen_i & ~flush_i & full_s & ~pop_s;

  // Next-state for pointers, occupancy and sticky overflow.
  always_comb begin
    wr_ptr_d   = wr_ptr_q;
    rd_ptr_d   = rd_ptr_q;
    count_d    = count_q;
    overflow_d = overflow_q | drop_s;
    if (flush_i) begin
      wr_ptr_d = '0;
      rd_ptr_d = '0;
      count_d  = '0;
    end else begin
      if (push_s) begin
        wr_ptr_d = wr_ptr_q + AW'(1);
      end else begin
        wr_ptr_d = wr_ptr_q;
      end
      if (pop_s) begin
        rd_ptr_d = rd_ptr_q + AW'(1);
      end else begin
        rd_ptr_d = rd_ptr_q;
      end
      case ({push_s, pop_s})
        2'b10:   count_d = count_q + (AW+1)'(1);
        2'b01:   count_d = count_q - (AW+1)'(1);
        default: count_d = count_q;
      endcase
    end
  end

  // State registers with synchronous reset.
  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr_q   <= '0;
      rd_ptr_q   <= '0;
      count_q    <= '0;
      overflow_q <= 1'b0;
    end else begin
      wr_ptr_q   <= wr_ptr_d;
      rd_ptr_q   <= rd_ptr_d;
      count_q    <= count_d;
      overflow_q <= overflow_d;
    end
  end

  assign wr_ptr_o      = wr_ptr_q;
  assign rd_ptr_o      = rd_ptr_q;
  assign count_o       = count_q;
  assign full_o        = full_s;
  assign almost_full_o = (count_q >= (DEPTH_C - (AW+1)'(1)));
  assign overflow_o    = overflow_q;
  assign rvalid_o      = ~empty_s | byp_s;
  assign push_o        = push_s;
  assign bypass_o      = byp_s;

endmodule

// File: rtl/id_ex_queue.sv
// ID->EX packet queue: circular storage with show-ahead head read.
// Optional ID_EX_QUEUE_BYPASS_EN forwards wData when the queue is empty.
module id_ex_queue import id_ex_queue_pkg::*; #(
  parameter int DEPTH = ID_EX_QUEUE_DEPTH,
  parameter int WIDTH = ID_EX_PACK_W,
  parameter int AW    = $clog2(DEPTH)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             wen,
  input  logic [WIDTH-1:0] wData,
  input  logic             flush,
  input  logic             rReady,
  output logic             rValid,
  output logic [WIDTH-1:0] rData,
  output logic [AW:0]      count,
  output logic             full,
  output logic             almostFull,
  output logic             overflow
);

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [AW-1:0]    wr_ptr_s, rd_ptr_s;
  logic             push_s, byp_s;

  id_ex_queue_ctrl #(
    .DEPTH (DEPTH),
    .AW    (AW)
  ) u_ctrl (
    .clk           (clk),
    .rst           (rst),
    .wen_i         (wen),
    .flush_i       (flush),
    .rready_i      (rReady),
    .wr_ptr_o      (wr_ptr_s),
    .rd_ptr_o      (rd_ptr_s),
    .count_o       (count),
    .full_o        (full),
    .almost_full_o (almostFull),
    .overflow_o    (overflow),
    .rvalid_o      (rValid),
    .push_o        (push_s),
    .bypass_o      (byp_s)
  );

  // Packet storage; contents are don't-care after reset.
  always_ff @(posedge clk) begin
    if (push_s) begin
      mem_q[wr_ptr_s] <= wData;
    end
  end

  // Head read mux.
  always_comb begin
    if (byp_s) begin
      rData = wData;
    end else begin
      rData = mem_q[rd_ptr_s];
    end
  end

endmodule

// File: doc/id_ex_queue.md
Name: id_ex_queue

Overview:
- Read-side end of the ID→EX pipeline FIFO interface.
- ID pushes one decoded packet per cycle (wData/wen): EX_DATA plus EX/MEM/WB control.
- This block buffers packets and presents them, oldest first, to the EX stage through a valid/ready pop handshake.
- Exports occupancy status to stall detection so ID stalls before overflow; supports a pipeline flush.

Parameters:
- DEPTH, 4, number of packet entries; power of two, at least 2.
- WIDTH, 192, packet width in bits; must equal the width of type_ID_EX_Pack.
- AW, $clog2(DEPTH), pointer width (derived; do not override).

Ports:
- clk  in  1  pipeline clock
- rst  in  1  synchronous active-high reset
- wen  in  1  ID push request (ID drives it as !ID_FLUSH)
- wData  in  WIDTH  packet from ID
- flush  in  1  discard all queued packets (exception or redirect from EX/MEM)
- rReady  in  1  EX accepts the head packet this cycle
- rValid  out  1  head packet valid
- rData  out  WIDTH  head packet (show-ahead)
- count  out  AW+1  number of entries held, 0..DEPTH
- full  out  1  count == DEPTH
- almostFull  out  1  count >= DEPTH-1; feeds IStallDetect to stall ID
- overflow  out  1  sticky; set when a push is dropped

Behaviour:
- Reset (rst=1 at posedge): wrPtr=0, rdPtr=0, count=0, rValid=0, full=0, almostFull=0, overflow=0. Storage contents are don't-care. rst overrides every other input.
- Storage is a circular register array. Pointers are AW bits and wrap naturally from DEPTH-1 to 0. count is tracked separately so full and empty are unambiguous.
- push = wen & !flush & (!full | pop).
- pop = rValid & rReady.
- rValid = (count != 0). rData = mem[rdPtr], combinational from registers, with no read latency.
- On push: mem[wrPtr] <= wData; wrPtr += 1.
- On pop: rdPtr += 1.
- count update: +1 on push only, -1 on pop only, unchanged when both or neither occur.
- Full, with wen and rReady both high in the same cycle: both take effect; count stays at DEPTH.
- Full, with wen high and rReady low: write is dropped, overflow <= 1. Cleared only by rst.
- Empty, with rReady high: no effect. rReady is ignored while rValid=0.
- flush: at the next edge, wrPtr=rdPtr=0 and count=0. A same-cycle wen is discarded (flush has priority, and overflow is not set). A same-cycle pop still completes, so EX consumes the head it was given. rValid=0 in the cycle after a flush.
- Latency: a pushed packet appears on rData/rValid in the cycle after the push edge.
- Throughput: one packet per cycle sustained.
- rReady may depend combinationally on rValid. rValid and rData never depend combinationally on rReady.
- count, full, almostFull and overflow are all registered or decoded from registers only.

Optional Feature:
- Macro: ID_EX_QUEUE_BYPASS_EN.
- Defined:
  - When count==0 and wen & !flush, rValid=1 and rData=wData combinationally, in the same cycle.
  - If rReady is also high, the packet is consumed without being written; pointers and count are unchanged.
  - Otherwise it is stored as a normal push.
  - Empty-queue latency drops to 0 cycles.
- Undefined:
  - Behaviour exactly as above; rValid and rData come purely from registers.

Decomposition:
- Shared pipeline package (already home to type_ID_EX_Pack) gains:
  - ID_EX_PACK_W, the constant $bits(type_ID_EX_Pack), used as WIDTH.
  - ID_EX_QUEUE_DEPTH, default 4.
- One sub-module is natural: queue_ctrl.
  - Holds pointers, count, full/almostFull/overflow and the push/pop decision.
  - Leaves id_ex_queue as storage array plus read mux.

Test Plan:
- After reset, push packets 0xA1, 0xA2, 0xA3 on consecutive cycles with rReady=0 → count=3, almostFull=1, full=0, rData=0xA1, rValid=1.
- Push 4 packets, then push 0xFF with rReady=0 → 0xFF dropped, overflow=1, count=4. Then pop 4 → 0xA1..0xA4 in order, rValid=0.
- Full queue, wen=1 (0xB5) and rReady=1 in the same cycle → count stays 4, head advances. 0xB5 is read out after three further pops; wrap-around verified over 3×DEPTH packets.
- count=3, assert flush with wen=1 and rReady=1 → head popped, new packet discarded. Next cycle: count=0, rValid=0, overflow unchanged.
- Assert rst while count=2 → next cycle: all outputs at reset values. A subsequent push of 0xC1 appears at rData one cycle later.
- With ID_EX_QUEUE_BYPASS_EN, empty queue, wen=1 (0xD7) with rReady=1 → rData=0xD7 and rValid=1 in the same cycle, count remains 0. Without the macro: rValid=0 that cycle, count=1 after the edge.
